timer8_apb_top: RTL and testbench
=================================

// Module: timer8_apb_top
// PURPOSE
//  8-bit programmable up/down timer with an APB3 slave register interface.
//  - Counter is loadable, selectable up/down, with a /1, /2, /4 or /8 prescaler.
//  - Sets sticky overflow/underflow flags and drives a maskable interrupt line.
//  - Sits on the peripheral APB bus; the single clock is pclk.
// PARAMETERS
//  ADDR_W  8  APB address width (byte addresses, one register per address)
//  DATA_W  8  register and counter width; fixed at 8 and not for override
// PORTS
//  pclk       in   1       sole clock; all state updates on its rising edge
//  presetn    in   1       reset, asynchronous, active-HIGH (legacy name kept)
//  psel       in   1       APB select
//  penable    in   1       APB access phase
//  pwrite     in   1       1 = write, 0 = read
//  paddr      in   ADDR_W  register address
//  pwdata     in   DATA_W  write data
//  prdata     out  DATA_W  read data
//  pready     out  1       transfer complete
//  interrupt  out  1       (TSR.ovf & TIE.ovf) | (TSR.udf & TIE.udf)
// BEHAVIOUR
//  Reset: every register and the prescaler clear to 0.
//    prdata=0, pready=0, interrupt=0.
//    Reset asserted mid-count aborts the count immediately.
//  APB:
//    pready = psel & penable (zero wait states).
//    A write commits on the clock edge where psel & penable & pwrite.
//    prdata is combinational from paddr when psel & !pwrite, else 0.
//    An unmapped address reads 0 and ignores writes.
//    Reserved bits read 0 and ignore writes.
//  Register map:
//    0x00 TDR   RW  [7:0] reload value
//    0x01 TCR   RW  [7]   load: while 1, cnt <= TDR every cycle and there is no counting
//                   [5]   dir: 0 = up, 1 = down
//                   [4]   en
//                   [1:0] cks: 00 = /1, 01 = /2, 10 = /4, 11 = /8
//    0x02 TSR   W1C [0] ovf, [1] udf (writing 0 has no effect)
//    0x03 TIE   RW  [0] ovf_en, [1] udf_en
//    0x04 TCNT  RO  [7:0] current count
//  Prescaler:
//    3-bit free-running counter, increments every pclk while en=1 and load=0.
//    Held at 0 when en=0 or load=1; cleared on any TCR write.
//    tick: /1 every cycle; /2 when pre[0]=1; /4 when pre[1:0]=3; /8 when pre=7.
//  Counting:
//    On a tick with en=1 and load=0, cnt increments (dir=0) or decrements (dir=1).
//    The count wraps modulo 256.
//    Overflow: up-count from 0xFF to 0x00 sets TSR.ovf on the same edge.
//    Underflow: down-count from 0x00 to 0xFF sets TSR.udf on the same edge.
//    Load has priority over counting; en=0 freezes cnt.
//  Flags:
//    Sticky until cleared by W1C.
//    A hardware set and a W1C clear on the same edge: the set wins.
//    interrupt is combinational from the registers and follows flag/enable changes with no extra cycle.
//    Clearing the flag or its enable deasserts interrupt.
// TESTING
//  1. After reset, read 0x00-0x04 -> all 0x00; interrupt=0; unmapped read 0x07 -> 0x00.
//  2. Write 0xA5 to TDR, 0xFF to TCR, 0x03 to TIE.
//       -> reads return 0xA5, 0xB3, 0x03 (reserved bits masked).
//  3. TDR=0xFD; TCR=0x80 then 0x10; TIE=0x01.
//       -> TCNT 0xFE, 0xFF, 0x00 on consecutive cycles; TSR=0x01; interrupt=1.
//       -> Write TSR=0x01 -> TSR=0, interrupt=0.
//  4. TDR=0x02; TCR=0x80 then 0x30; TIE=0x00.
//       -> TCNT reaches 0xFF and TSR=0x02, but interrupt stays 0.
//  5. cks=01/10/11 from TCNT=0: after 16 pclk, TCNT = 8/4/2 (/1 gives 16).
//  6. Assert presetn while counting with TSR.ovf=1 -> all registers 0, interrupt=0 at once.

Source files
------------

// File: rtl/timer8_apb_top.sv
// timer8_apb_top: 8-bit up/down timer with prescaler, sticky flags and APB3 register interface
module timer8_apb_top #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              interrupt
);
    logic [7:0] tdr, cnt;
    logic       load, dir, en;
    logic [1:0] cks, tsr, tie;
    logic [2:0] pre;
    logic       wr, wr_tdr, wr_tcr, wr_tsr, wr_tie, tick, run, set_ovf, set_udf;
    always_comb begin
        wr      = psel & penable & pwrite;
        wr_tdr  = wr & (paddr == ADDR_W'(0));
        wr_tcr  = wr & (paddr == ADDR_W'(1));
        wr_tsr  = wr & (paddr == ADDR_W'(2));
        wr_tie  = wr & (paddr == ADDR_W'(3));
        tick    = cks == 2'd0 ? 1'b1 : cks == 2'd1 ? pre[0] : cks == 2'd2 ? &pre[1:0] : &pre;
        run     = en & ~load & tick;
        set_ovf = run & ~dir & (cnt == 8'hff);
        set_udf = run & dir & (cnt == 8'h00);
    end
    // hardware flag set wins over a same-edge W1C clear
    always_ff @(posedge pclk or posedge presetn) begin
        if (presetn) begin
            tdr  <= '0;
            cnt  <= '0;
            load <= 1'b0;
            dir  <= 1'b0;
            en   <= 1'b0;
            cks  <= '0;
            tsr  <= '0;
            tie  <= '0;
            pre  <= '0;
        end else begin
            if (wr_tdr) tdr <= pwdata;
            if (wr_tcr) {load, dir, en, cks} <= {pwdata[7], pwdata[5:4], pwdata[1:0]};
            if (wr_tie) tie <= pwdata[1:0];
            tsr <= {set_udf, set_ovf} | (tsr & ~(wr_tsr ? pwdata[1:0] : 2'b00));
            pre <= (wr_tcr | ~en | load) ? 3'd0 : pre + 3'd1;
            cnt <= load ? tdr : run ? (dir ? cnt - 8'd1 : cnt + 8'd1) : cnt;
        end
    end
    always_comb begin
        prdata    = !(psel && !pwrite) ? '0 :
                    paddr == ADDR_W'(0) ? tdr :
                    paddr == ADDR_W'(1) ? {load, 1'b0, dir, en, 2'b00, cks} :
                    paddr == ADDR_W'(2) ? {6'd0, tsr} :
                    paddr == ADDR_W'(3) ? {6'd0, tie} :
                    paddr == ADDR_W'(4) ? cnt : '0;
        pready    = psel & penable;
        interrupt = |(tsr & tie);
    end
endmodule

// File: tb/tb_timer8_apb_top.sv
// tb_timer8_apb_top: vector table, directed corner sequences and randomized traffic against a reference model
module tb_timer8_apb_top;
    logic       pclk = 0, presetn = 0, psel = 0, penable = 0, pwrite = 0;
    logic [7:0] paddr = 0, pwdata = 0, prdata;
    logic       pready, interrupt;
    int vectors = 0, miscompares = 0;
    int m_tdr, m_tcr, m_tsr, m_tie, m_cnt, m_phase;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[15];

    timer8_apb_top dut (
        .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .interrupt(interrupt)
    );

    always #5 pclk = ~pclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic model_clear();
        m_tdr = 0; m_tcr = 0; m_tsr = 0; m_tie = 0; m_cnt = 0; m_phase = 0;
    endtask

    // one rising edge of behaviour, from the bus values present at that edge
    task automatic model_step();
        int n_cnt, n_phase, n_tsr, div, sets;
        bit wr, load, en, down;
        if (presetn) begin
            model_clear();
            return;
        end
        wr   = psel && penable && pwrite;
        load = ((m_tcr >> 7) & 1) != 0;
        down = ((m_tcr >> 5) & 1) != 0;
        en   = ((m_tcr >> 4) & 1) != 0;
        div  = 1 << (m_tcr & 3);
        n_cnt = m_cnt;
        sets = 0;
        if (load) n_cnt = m_tdr;
        else if (en && (m_phase % div) == div - 1) begin
            if (down) begin
                n_cnt = m_cnt - 1;
                if (n_cnt < 0) begin n_cnt += 256; sets = 2; end
            end else begin
                n_cnt = m_cnt + 1;
                if (n_cnt > 255) begin n_cnt -= 256; sets = 1; end
            end
        end
        n_phase = (en && !load) ? (m_phase + 1) % 8 : 0;
        n_tsr = m_tsr;
        if (wr) begin
            case (int'(paddr))
                0: m_tdr = int'(pwdata);
                1: begin m_tcr = int'(pwdata) & 'hB3; n_phase = 0; end
                2: n_tsr = m_tsr & ~int'(pwdata) & 3;
                3: m_tie = int'(pwdata) & 3;
                default: ;
            endcase
        end
        m_tsr = n_tsr | sets;
        m_cnt = n_cnt;
        m_phase = n_phase;
    endtask

    function automatic int model_read(input int a);
        case (a)
            0: return m_tdr;
            1: return m_tcr;
            2: return m_tsr;
            3: return m_tie;
            4: return m_cnt;
            default: return 0;
        endcase
    endfunction

    task automatic cycle();
        model_step();
        @(posedge pclk);
        #1;
    endtask

    task automatic peek(input logic [7:0] a, output logic [7:0] d);
        logic s, e, w;
        logic [7:0] pa;
        s = psel; e = penable; w = pwrite; pa = paddr;
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        #1;
        d = prdata;
        psel = s; penable = e; pwrite = w; paddr = pa;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        cycle();
        penable = 1;
        cycle();
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic do_reset();
        presetn = 1;
        cycle();
        cycle();
        presetn = 0;
    endtask

    initial begin
        logic [7:0] r, a, d;
        int exp5[4];
        exp5 = '{16, 8, 4, 2};
        tbl[0]  = '{0, 8'h00, 8'h00, 8'h00};
        tbl[1]  = '{0, 8'h01, 8'h00, 8'h00};
        tbl[2]  = '{0, 8'h02, 8'h00, 8'h00};
        tbl[3]  = '{0, 8'h03, 8'h00, 8'h00};
        tbl[4]  = '{0, 8'h04, 8'h00, 8'h00};
        tbl[5]  = '{0, 8'h07, 8'h00, 8'h00};
        tbl[6]  = '{1, 8'h00, 8'hA5, 8'h00};
        tbl[7]  = '{1, 8'h01, 8'hFF, 8'h00};
        tbl[8]  = '{1, 8'h03, 8'h03, 8'h00};
        tbl[9]  = '{0, 8'h00, 8'h00, 8'hA5};
        tbl[10] = '{0, 8'h01, 8'h00, 8'hB3};
        tbl[11] = '{0, 8'h03, 8'h00, 8'h03};
        tbl[12] = '{0, 8'h04, 8'h00, 8'hA5};
        tbl[13] = '{1, 8'h01, 8'h00, 8'h00};
        tbl[14] = '{0, 8'h04, 8'h00, 8'hA5};

        do_reset();
        check("reset_irq", interrupt, 0);
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].wr) apb_write(tbl[i].addr, tbl[i].data);
            else begin
                peek(tbl[i].addr, r);
                check($sformatf("tbl%0d_addr%0h", i, tbl[i].addr), r, tbl[i].exp);
            end
        end
        check("tbl_irq", interrupt, 0);
        psel = 0; paddr = 0; #1;
        check("idle_prdata", prdata, 0);
        psel = 1; pwrite = 0; penable = 0; #1;
        check("setup_pready", pready, 0);
        penable = 1; #1;
        check("access_pready", pready, 1);
        psel = 0; penable = 0;

        do_reset();
        apb_write(8'h03, 8'h01);
        apb_write(8'h00, 8'hFD);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h10);
        peek(8'h04, r); check("ovf_load", r, 8'hFD);
        cycle(); peek(8'h04, r); check("ovf_cnt_fe", r, 8'hFE);
        cycle(); peek(8'h04, r); check("ovf_cnt_ff", r, 8'hFF);
        check("ovf_irq_before", interrupt, 0);
        cycle(); peek(8'h04, r); check("ovf_cnt_00", r, 8'h00);
        peek(8'h02, r); check("ovf_tsr", r, 8'h01);
        check("ovf_irq", interrupt, 1);
        apb_write(8'h02, 8'h01);
        peek(8'h02, r); check("ovf_w1c_tsr", r, 8'h00);
        check("ovf_w1c_irq", interrupt, 0);
        apb_write(8'h01, 8'h00);

        apb_write(8'h03, 8'h00);
        apb_write(8'h00, 8'h02);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h30);
        repeat (3) cycle();
        peek(8'h04, r); check("udf_cnt_ff", r, 8'hFF);
        peek(8'h02, r); check("udf_tsr", r, 8'h02);
        check("udf_irq_masked", interrupt, 0);
        apb_write(8'h03, 8'h02);
        check("udf_irq_enabled", interrupt, 1);
        apb_write(8'h01, 8'h00);

        for (int c = 0; c < 4; c++) begin
            do_reset();
            apb_write(8'h01, 8'(8'h10 | c));
            repeat (16) cycle();
            peek(8'h04, r);
            check($sformatf("presc_cks%0d", c), r, exp5[c]);
        end

        do_reset();
        apb_write(8'h03, 8'h01);
        apb_write(8'h00, 8'hFF);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h10);
        cycle();
        check("rst_pre_irq", interrupt, 1);
        cycle(); cycle();
        presetn = 1;
        model_clear();
        #1;
        check("rst_irq", interrupt, 0);
        peek(8'h04, r); check("rst_tcnt", r, 0);
        peek(8'h02, r); check("rst_tsr", r, 0);
        peek(8'h01, r); check("rst_tcr", r, 0);
        presetn = 0;

        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) cycle();
            else begin
                a = 8'($urandom_range(0, 7));
                d = 8'($urandom);
                if (a == 8'h01 && $urandom_range(0, 3) != 0) d[7] = 1'b0;
                if (a == 8'h02 && $urandom_range(0, 2) != 0) a = 8'h04;
                apb_write(a, d);
            end
            peek(8'h04, r); check("rand_tcnt", r, model_read(4));
            peek(8'h02, r); check("rand_tsr", r, model_read(2));
            check("rand_irq", interrupt, (m_tsr & m_tie) != 0 ? 1 : 0);
            a = 8'($urandom_range(0, 7));
            peek(a, r); check($sformatf("rand_read%0h", a), r, model_read(int'(a)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
